// File: rtl/avmm_sample_responder.sv
// Avalon-MM pipelined read responder that returns pairs of 16-bit samples from
// an on-chip sample memory as 32-bit words. Reads are queued and answered in order.
module avmm_sample_responder #(
  parameter int unsigned SADDR_W = 8,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               avs_read,
  input  logic [22:0]        avs_address,
  input  logic [3:0]         avs_byteenable,
  output logic               avs_waitrequest,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic [SADDR_W-1:0] s_addr,
  input  logic [15:0]        s_readdata,
  output logic               oob_err
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRdLo, StRdHi, StCapture} state_e;

  state_e            state_q, state_d;
  logic [22:0]       q_addr [QDEPTH];
  logic [3:0]        q_be   [QDEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       lo_q;
  logic              push, pop;
  logic [22:0]       head_addr;
  logic [3:0]        head_be;
  logic              head_oob;
  logic [31:0]       word;
  logic [31:0]       word_masked;

  // Full-queue backpressure from registered state only; held high during reset.
  assign avs_waitrequest = !rst_n || (count_q == CntW'(QDEPTH));
  assign push            = avs_read && !avs_waitrequest;
  assign pop             = (state_q == StCapture);

  assign head_addr = q_addr[head_q];
  assign head_be   = q_be[head_q];
  // Any word-address bit at or above the memory's word range makes the read out of range.
  assign head_oob  = |(head_addr >> (SADDR_W - 1));

  // Assemble the outgoing word: hi sample arrives during CAPTURE, lo was latched earlier.
  always_comb begin
    word        = head_oob ? 32'h0 : {s_readdata, lo_q};
    word_masked = word;
    for (int i = 0; i < 4; i++) begin
      if (!head_be[i]) word_masked[8*i +: 8] = 8'h00;
    end
  end

  // Occupancy after this edge, accounting for simultaneous push and pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  // Next-state and sample-memory address decode.
  always_comb begin
    state_d = state_q;
    s_addr  = '0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StRdLo;
      end
      StRdLo: begin
        s_addr  = {head_addr[SADDR_W-2:0], 1'b0};
        state_d = StRdHi;
      end
      StRdHi: begin
        s_addr  = {head_addr[SADDR_W-2:0], 1'b1};
        state_d = StCapture;
      end
      StCapture: begin
        state_d = (count_d != '0) ? StRdLo : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Command storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail_q] <= avs_address;
      q_be[tail_q]   <= avs_byteenable;
    end
  end

  // Queue pointers, FSM state, response registers and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      state_q           <= StIdle;
      lo_q              <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      oob_err           <= 1'b0;
    end else begin
      count_q           <= count_d;
      state_q           <= state_d;
      avs_readdatavalid <= pop;
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop) begin
        head_q       <= head_q + PtrW'(1);
        avs_readdata <= word_masked;
        if (head_oob) oob_err <= 1'b1;
      end
      // The lo sample addressed in RD_LO is on s_readdata during RD_HI.
      if (state_q == StRdHi) lo_q <= s_readdata;
    end
  end

endmodule

// File: tb/tb_avmm_sample_responder.sv
// Self-checking bench for avmm_sample_responder: a queue-based transaction model
// predicts every response word and its arrival edge; directed tests pin literals.
module tb_avmm_sample_responder;

  localparam int SADDR_W = 8;
  localparam int QDEPTH  = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               avs_read = 1'b0;
  logic [22:0]        avs_address = '0;
  logic [3:0]         avs_byteenable = '0;
  logic               avs_waitrequest;
  logic [31:0]        avs_readdata;
  logic               avs_readdatavalid;
  logic [SADDR_W-1:0] s_addr;
  logic [15:0]        s_readdata;
  logic               oob_err;

  avmm_sample_responder #(.SADDR_W(SADDR_W), .QDEPTH(QDEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .avs_read         (avs_read),
    .avs_address      (avs_address),
    .avs_byteenable   (avs_byteenable),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .s_addr           (s_addr),
    .s_readdata       (s_readdata),
    .oob_err          (oob_err)
  );

  always #5 clk = ~clk;

  // Sample memory: synchronous read, sample[i] = 0x1000 + i.
  logic [15:0] mem [1 << SADDR_W];
  always @(posedge clk) s_readdata <= mem[s_addr];

  typedef struct {
    logic [31:0] data;
    int          pe;    // edge number after which readdatavalid is high
    logic        oob;
    int          w;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt = 0;
  int          p_last = -100;
  logic [31:0] last_data = '0;
  logic        model_oob = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] seen_q[$];
  int          seen_e[$];
  int          acc_e[$];
  logic        wr_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Expected word and arrival edge for a command accepted at edge acc.
  function automatic exp_t predict(input logic [22:0] a, input logic [3:0] be, input int acc);
    exp_t        e;
    logic [31:0] d;
    e.oob = (a >> (SADDR_W - 1)) != 0;
    e.w   = int'(a) % (1 << (SADDR_W - 1));
    d     = e.oob ? 32'h0 : {mem[2*e.w+1], mem[2*e.w]};
    for (int i = 0; i < 4; i++) if (!be[i]) d[8*i +: 8] = 8'h00;
    e.data = d;
    // Idle responder needs 4 edges; a queued word follows its predecessor by 3.
    e.pe = (acc <= p_last) ? p_last + 3 : acc + 4;
    return e;
  endfunction

  // Accept monitor: records every handshake into the model.
  always @(posedge clk) begin
    exp_t e;
    edge_cnt++;
    if (rst_n && avs_read && !avs_waitrequest) begin
      e = predict(avs_address, avs_byteenable, edge_cnt);
      exp_q.push_back(e);
      p_last = e.pe;
      acc_e.push_back(edge_cnt);
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic exp_v;
    int   d;
    exp_t f;
    while (exp_q.size() > 0 && exp_q[0].pe < edge_cnt) void'(exp_q.pop_front());
    exp_v = (exp_q.size() > 0) && (exp_q[0].pe == edge_cnt);
    check("readdatavalid", avs_readdatavalid, exp_v);
    if (avs_readdatavalid) begin
      seen_q.push_back(avs_readdata);
      seen_e.push_back(edge_cnt);
    end
    if (exp_v) begin
      f = exp_q.pop_front();
      last_data = f.data;
      if (f.oob) model_oob = 1'b1;
    end
    check("readdata", avs_readdata, last_data);
    check("oob_err", oob_err, model_oob);
    check("waitrequest", avs_waitrequest, !rst_n || exp_q.size() == QDEPTH);
    if (exp_q.size() == 0) begin
      check("s_addr_idle", s_addr, 0);
    end else begin
      d = exp_q[0].pe - edge_cnt;
      if (d == 3)      check("s_addr_lo", s_addr, 2 * exp_q[0].w);
      else if (d == 2) check("s_addr_hi", s_addr, 2 * exp_q[0].w + 1);
      else if (d >= 4) check("s_addr_wait", s_addr, 0);
    end
  end

  // Present a command (called between edges) and return one negedge after acceptance.
  task automatic issue(input logic [22:0] a, input logic [3:0] be);
    int n = 0;
    avs_read = 1'b1;
    avs_address = a;
    avs_byteenable = be;
    #1;
    while (avs_waitrequest && n < 100) begin
      wr_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (avs_waitrequest) check("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // Drop the request and scribble the bus to show the address is not reused.
  task automatic idle_bus();
    avs_read = 1'b0;
    avs_address = '1;
    avs_byteenable = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    seen_q.delete();
    seen_e.delete();
    acc_e.delete();
  endtask

  logic [31:0] t2_tbl [6] = '{32'h10011000, 32'h10031002, 32'h10051004,
                              32'h10071006, 32'h10091008, 32'h100B100A};

  initial begin
    for (int i = 0; i < (1 << SADDR_W); i++) mem[i] = 16'h1000 + 16'(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_waitrequest", avs_waitrequest, 1);
    check("rst_valid", avs_readdatavalid, 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_oob", oob_err, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single read of word 5: s_addr 10 then 11, data after 4 edges.
    clear_logs();
    issue(23'd5, 4'hF);
    idle_bus();
    @(negedge clk);
    check("t1_s_addr_lo", s_addr, 10);
    @(negedge clk);
    check("t1_s_addr_hi", s_addr, 11);
    wait_idle();
    check("t1_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      check("t1_data", seen_q[0], 32'h100B100A);
      check("t1_latency", seen_e[0] - acc_e[0], 4);
    end

    // Back-to-back reads 0..5 fill the queue and stall the master.
    clear_logs();
    wr_seen = 1'b0;
    for (int k = 0; k < 6; k++) issue(23'(k), 4'hF);
    idle_bus();
    wait_idle();
    check("t2_stalled", wr_seen, 1);
    check("t2_count", seen_q.size(), 6);
    if (seen_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check("t2_data", seen_q[i], t2_tbl[i]);
      for (int i = 1; i < 6; i++) check("t2_spacing", seen_e[i] - seen_e[i-1], 3);
    end

    // Byteenable masking.
    clear_logs();
    issue(23'd3, 4'b0101);
    idle_bus();
    wait_idle();
    check("t3_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) check("t3_data", seen_q[0], 32'h00070006);

    // Out-of-range word returns zero and sets the sticky error.
    clear_logs();
    issue(23'd128, 4'hF);
    idle_bus();
    wait_idle();
    check("t4_oob_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) check("t4_oob_data", seen_q[0], 32'h0);
    check("t4_oob_set", oob_err, 1);
    clear_logs();
    issue(23'd1, 4'hF);
    idle_bus();
    wait_idle();
    check("t4_next_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) check("t4_next_data", seen_q[0], 32'h10031002);
    check("t4_oob_sticky", oob_err, 1);

    // Reset during the first word's RD_HI drops all pending reads.
    clear_logs();
    issue(23'd0, 4'hF);
    issue(23'd1, 4'hF);
    issue(23'd2, 4'hF);
    avs_read = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    last_data = '0;
    model_oob = 1'b0;
    p_last = -100;
    repeat (3) @(negedge clk);
    check("t5_wr_in_reset", avs_waitrequest, 1);
    #2 rst_n = 1'b1;
    #1;
    issue(23'd2, 4'hF);
    idle_bus();
    wait_idle();
    check("t5_count", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      check("t5_data", seen_q[0], 32'h10051004);
      check("t5_latency", seen_e[0] - acc_e[acc_e.size()-1], 4);
    end

    // Push and pop on the same edge with two queued.
    clear_logs();
    issue(23'd0, 4'hF);
    issue(23'd1, 4'hF);
    idle_bus();
    repeat (2) @(negedge clk);
    issue(23'd2, 4'hF);
    check("t6_wr_low", avs_waitrequest, 0);
    idle_bus();
    wait_idle();
    check("t6_count", seen_q.size(), 3);
    if (seen_q.size() == 3 && acc_e.size() == 3) begin
      check("t6_same_edge", seen_e[0], acc_e[2]);
      check("t6_data0", seen_q[0], 32'h10011000);
      check("t6_data1", seen_q[1], 32'h10031002);
      check("t6_data2", seen_q[2], 32'h10051004);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/avmm_sample_responder.md
Name: avmm_sample_responder

Overview:
Avalon-MM pipelined-read responder that serves 32-bit read commands from a 16-bit on-chip sample memory. It packs two consecutive samples per word: lower address in readdata[15:0], upper address in readdata[31:16]. It lets a flash-style reader master run against on-chip sample storage with the same read/waitrequest/readdatavalid handshake. Read-only; burstcount fixed at 1.

Parameters:
SADDR_W, 8, sample memory address width (2^SADDR_W 16-bit samples, 2^(SADDR_W-1) words).
QDEPTH, 4, command queue depth (max outstanding accepted reads); power of 2, >=2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
avs_read  in  1  read request, qualified by avs_waitrequest.
avs_address  in  23  word address.
avs_byteenable  in  4  byte lanes returned; disabled lanes read 0.
avs_waitrequest  out  1  command not accepted this cycle.
avs_readdata  out  32  packed sample pair, registered.
avs_readdatavalid  out  1  one-cycle pulse per accepted read, in order.
s_addr  out  SADDR_W  sample memory address.
s_readdata  in  16  sample memory q; synchronous read, valid the cycle after the address is sampled.
oob_err  out  1  sticky; a word address beyond memory was read.

Behaviour:
- Reset (async, rst_n low): queue emptied, FSM to IDLE, avs_readdata=0, avs_readdatavalid=0, s_addr=0, oob_err=0. avs_waitrequest=1 while rst_n low.
- avs_waitrequest = !rst_n | (count==QDEPTH); derived from registered state only, never from avs_read.
- Accept: edge where avs_read=1 and avs_waitrequest=0. Push {avs_address, avs_byteenable} into the queue. The master holds its command while waitrequest=1.
- Queue: circular, QDEPTH entries, head/tail pointers plus a count of QDEPTH+1 range. Push and pop on the same edge leave count unchanged. There is no bypass when full: waitrequest stays 1 in the cycle of a pop.
- FSM states:
  - IDLE: s_addr=0. If count>0, go to RD_LO.
  - RD_LO: s_addr={head.addr[SADDR_W-2:0],0}. Go to RD_HI.
  - RD_HI: s_addr={head.addr[SADDR_W-2:0],1}. Latch lo=s_readdata. Go to CAPTURE.
  - CAPTURE: capture hi=s_readdata. At the exiting edge, register avs_readdata={hi,lo} masked per byteenable, pulse avs_readdatavalid, and pop the queue. Go to RD_LO if count after pop >0, else IDLE.
- Latency: with FSM idle and queue empty, a command accepted at edge E0 has readdatavalid high in the cycle after edge E4. Throughput is one word per 3 cycles when back-to-back.
- avs_readdatavalid is high exactly one cycle per word. avs_readdata holds its value between pulses.
- Out of range: any of avs_address[22:SADDR_W-1] nonzero. The word still takes the full 3-cycle slot for uniform timing, returns 32'h0, and sets oob_err at CAPTURE. oob_err clears only on reset.
- Byteenable mask: lane i (bits 8i+7:8i) is forced to 0 when byteenable[i]=0.
- Reset mid-operation: all pending reads are dropped and no readdatavalid is issued for them. After release, the first accept is possible on the first edge.
- avs_address is used only at acceptance; later changes on the bus have no effect.

Test Plan:
- Memory preloaded with sample[i]=16'h1000+i. Single read of addr 5 -> readdatavalid exactly 4 edges after accept, readdata=32'h100B100A; s_addr sequence 10 then 11.
- avs_read held high for addrs 0..5 -> waitrequest=1 while 4 are queued. Six pulses in order: 32'h10011000, 32'h10031002, … 32'h100B100A, spaced 3 cycles apart. No command dropped or duplicated.
- Read addr 3 with byteenable=4'b0101 -> readdata=32'h00070006.
- Read addr 128 (SADDR_W=8) -> readdata=32'h0, oob_err rises and stays 1. Subsequent read of addr 1 -> 32'h10031002 with oob_err still 1.
- Queue 3 reads, pulse rst_n low during the first word's RD_HI -> no readdatavalid for any of them. waitrequest=1 during reset. A read of addr 2 after release -> 32'h10051004 with 4-edge latency.
- Push and pop on the same edge with count=2 -> count stays 2, waitrequest stays 0, order preserved.
